// File: rtl/temp_alarm_pkg.sv
// Shared types and constants for the temperature alarm sequencer.
// Holds the alarm level encoding, the lamp patterns and small sizing helpers.
package temp_alarm_pkg;

    typedef enum logic [1:0] {
        LVL_NORMAL = 2'd0,
        LVL_BORDER = 2'd1,
        LVL_WARN   = 2'd2,
        LVL_EMERG  = 2'd3
    } level_t;

    localparam logic [3:0] LED_NORMAL = 4'b0001;
    localparam logic [3:0] LED_BORDER = 4'b0010;
    localparam logic [3:0] LED_WARN   = 4'b0100;
    localparam logic [3:0] LED_EMERG  = 4'b1000;
    localparam logic [3:0] LED_OFF    = 4'b0000;

    // The persist counter must reach the larger of the two thresholds.
    function automatic int persist_width(input int esc, input int deesc);
        int m;
        m = (esc > deesc) ? esc : deesc;
        return $clog2(m) + 1;
    endfunction

    function automatic logic [3:0] led_onehot(input level_t lvl);
        logic [3:0] led;
        case (lvl)
            LVL_NORMAL: led = LED_NORMAL;
            LVL_BORDER: led = LED_BORDER;
            LVL_WARN:   led = LED_WARN;
            LVL_EMERG:  led = LED_EMERG;
            default:    led = LED_NORMAL;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/temp_alarm_if.sv
// Bundle between temp_state / operator key and the alarm sequencer:
// class flags and acknowledge in, alarm level and lamp/buzzer drives out.
interface temp_alarm_if;
    logic       normal;
    logic       border_line;
    logic       warning;
    logic       emergency;
    logic       ack;
    logic [1:0] level;
    logic [3:0] led_alarm;
    logic       buzzer;
    logic       acked;

    modport master (
        output normal, border_line, warning, emergency, ack,
        input  level, led_alarm, buzzer, acked
    );

    modport slave (
        input  normal, border_line, warning, emergency, ack,
        output level, led_alarm, buzzer, acked
    );
endinterface

// File: rtl/temp_alarm_tick.sv
// Free-running divider: one-cycle tick strobe every TICK_DIV clocks,
// the common time base for lamp blinking and request filtering.
module tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_r;

    // Divider count, wraps after the strobe cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/temp_alarm_ctrl.sv
// Alarm sequencer: filters temperature-class flags with persistence and hysteresis,
// keeps the alarm level, and drives the lamp bank, buzzer and operator acknowledge.
module temp_alarm_ctrl
    import temp_alarm_pkg::*;
#(
    parameter int TICK_DIV    = 25_000_000,
    parameter int ESC_TICKS   = 2,
    parameter int DEESC_TICKS = 4
) (
    input  logic          clk,
    input  logic          rst,
    temp_alarm_if.slave   bus
);
    localparam int PW   = persist_width(ESC_TICKS, DEESC_TICKS);
    localparam int PMAX = (ESC_TICKS > DEESC_TICKS) ? ESC_TICKS : DEESC_TICKS;
    localparam logic [PW-1:0] PMAX_V  = PW'(PMAX);
    localparam logic [PW-1:0] ESC_V   = PW'(ESC_TICKS);
    localparam logic [PW-1:0] DEESC_V = PW'(DEESC_TICKS);

    logic          tick_s;
    level_t        req_r, req_s;
    level_t        level_r, level_s;
    level_t        pending_r, pending_s;
    logic [PW-1:0] pcnt_r, pcnt_s;
    logic          phase_r;
    logic          acked_r, acked_s;
    logic          ack_sync1_r, ack_sync2_r, ack_prev_r;
    logic          ack_rise_s;
    logic [3:0]    led_s;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Priority decode of the class flags; no flag keeps the previous request.
    always_comb begin
        req_s = req_r;
        if (bus.emergency) begin
            req_s = LVL_EMERG;
        end else if (bus.warning) begin
            req_s = LVL_WARN;
        end else if (bus.border_line) begin
            req_s = LVL_BORDER;
        end else if (bus.normal) begin
            req_s = LVL_NORMAL;
        end else begin
            req_s = req_r;
        end
    end

    // Level FSM with persistence filter; emergency bypasses the tick wait.
    always_comb begin
        level_s   = level_r;
        pending_s = pending_r;
        pcnt_s    = pcnt_r;
        if (req_r == LVL_EMERG && level_r != LVL_EMERG) begin
            level_s = LVL_EMERG;
            pcnt_s  = '0;
        end else if (tick_s) begin
            if (req_r == level_r) begin
                pcnt_s = '0;
            end else if (req_r != pending_r) begin
                pending_s = req_r;
                pcnt_s    = PW'(1);
            end else if (pcnt_r < PMAX_V) begin
                pcnt_s = pcnt_r + PW'(1);
            end else begin
                pcnt_s = pcnt_r;
            end
            if (req_r > level_r && pcnt_s >= ESC_V) begin
                level_s = req_r;
                pcnt_s  = '0;
            end else if (req_r < level_r && pcnt_s >= DEESC_V) begin
                level_s = req_r;
                pcnt_s  = '0;
            end else begin
                level_s = level_r;
            end
        end else begin
            level_s = level_r;
        end
    end

    // A level change always clears the acknowledge, even on a coincident ack edge.
    always_comb begin
        acked_s = acked_r;
        if (level_s != level_r) begin
            acked_s = 1'b0;
        end else if (ack_rise_s && level_r >= LVL_WARN) begin
            acked_s = 1'b1;
        end else begin
            acked_s = acked_r;
        end
    end

    assign ack_rise_s = ack_sync2_r & ~ack_prev_r;

    // State, filter, acknowledge and blink registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r       <= LVL_NORMAL;
            level_r     <= LVL_NORMAL;
            pending_r   <= LVL_NORMAL;
            pcnt_r      <= '0;
            phase_r     <= 1'b0;
            acked_r     <= 1'b0;
            ack_sync1_r <= 1'b0;
            ack_sync2_r <= 1'b0;
            ack_prev_r  <= 1'b0;
        end else begin
            req_r       <= req_s;
            level_r     <= level_s;
            pending_r   <= pending_s;
            pcnt_r      <= pcnt_s;
            phase_r     <= tick_s ? ~phase_r : phase_r;
            acked_r     <= acked_s;
            ack_sync1_r <= bus.ack;
            ack_sync2_r <= ack_sync1_r;
            ack_prev_r  <= ack_sync2_r;
        end
    end

    // Warning and emergency lamps blink until acknowledged.
    always_comb begin
        led_s = led_onehot(level_r);
        if (level_r >= LVL_WARN && !acked_r && phase_r) begin
            led_s = LED_OFF;
        end else begin
            led_s = led_onehot(level_r);
        end
    end

    assign bus.level     = level_r;
    assign bus.led_alarm = led_s;
    assign bus.buzzer    = (level_r == LVL_EMERG) & ~acked_r;
    assign bus.acked     = acked_r;

endmodule

// File: tb/tb_temp_alarm_ctrl.sv
// Directed scoreboard bench for temp_alarm_ctrl with TICK_DIV=4, ESC=2, DEESC=4.
module tb_temp_alarm_ctrl;

    typedef struct {
        string      name;
        logic [1:0] lvl;
        logic [3:0] led;
        logic       bz;
        logic       ac;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ecnt;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    temp_alarm_if bus();

    temp_alarm_ctrl #(
        .TICK_DIV    (4),
        .ESC_TICKS   (2),
        .DEESC_TICKS (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Edge counter since reset release: a tick is applied on every edge where ecnt%4==0.
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    // Monitor: compares every queued expectation against the DUT outputs.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (bus.level !== e.lvl || bus.led_alarm !== e.led ||
                bus.buzzer !== e.bz || bus.acked !== e.ac) begin
                n_err++;
                $display("FAIL %s: got level=%0d led=%b buzzer=%b acked=%b, want level=%0d led=%b buzzer=%b acked=%b",
                         e.name, bus.level, bus.led_alarm, bus.buzzer, bus.acked,
                         e.lvl, e.led, e.bz, e.ac);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_tick(input int n);
        for (int i = 0; i < n; i++) begin
            do step(); while (ecnt % 4 != 0);
        end
    endtask

    task automatic set_flags(input logic n, input logic b, input logic w, input logic e);
        bus.normal      = n;
        bus.border_line = b;
        bus.warning     = w;
        bus.emergency   = e;
    endtask

    // Expected lamp: one-hot level, dark in odd blink phase for unacked levels 2/3.
    task automatic expect_state(input string name, input logic [1:0] lvl, input logic ac);
        exp_t e;
        logic [3:0] led;
        led = 4'b0001 << lvl;
        if (lvl >= 2'd2 && !ac && ((ecnt / 4) % 2 == 1)) led = 4'b0000;
        e.name = name;
        e.lvl  = lvl;
        e.led  = led;
        e.bz   = (lvl == 2'd3) && !ac;
        e.ac   = ac;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        bus.ack = 1'b0;
        #1;
        expect_state("reset_state", 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Warning for a single tick does not escalate.
        to_tick(1);
        set_flags(1'b0, 1'b0, 1'b1, 1'b0);
        to_tick(1);
        expect_state("warn_1tick_a", 2'd0, 1'b0);
        set_flags(1'b1, 1'b0, 1'b0, 1'b0);
        to_tick(1);
        expect_state("warn_1tick_b", 2'd0, 1'b0);
        to_tick(1);
        expect_state("warn_1tick_hold", 2'd0, 1'b0);

        // Warning held: escalates on the second tick, then blinks.
        set_flags(1'b0, 1'b0, 1'b1, 1'b0);
        to_tick(1);
        expect_state("warn_tick1", 2'd0, 1'b0);
        to_tick(1);
        expect_state("warn_tick2_lit", 2'd2, 1'b0);
        to_tick(1);
        expect_state("warn_tick3_dark", 2'd2, 1'b0);

        // Emergency two clocks after the flag, no tick wait.
        set_flags(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        expect_state("emerg_1clk", 2'd2, 1'b0);
        step();
        expect_state("emerg_2clk", 2'd3, 1'b0);
        to_tick(1);
        expect_state("emerg_blink_on", 2'd3, 1'b0);
        to_tick(1);
        expect_state("emerg_blink_off", 2'd3, 1'b0);

        // Acknowledge at emergency: latched three clocks after the rise.
        bus.ack = 1'b1;
        step();
        step();
        expect_state("ack_2clk", 2'd3, 1'b0);
        bus.ack = 1'b0;
        step();
        expect_state("ack_3clk", 2'd3, 1'b1);
        to_tick(1);
        set_flags(1'b1, 1'b0, 1'b0, 1'b0);
        to_tick(3);
        expect_state("deesc_3ticks", 2'd3, 1'b1);
        to_tick(1);
        expect_state("deesc_4ticks", 2'd0, 1'b0);

        // Acknowledge at level 0 is ignored.
        bus.ack = 1'b1;
        step();
        step();
        bus.ack = 1'b0;
        repeat (3) step();
        expect_state("ack_at_normal", 2'd0, 1'b0);

        // Alternating lower requests never satisfy de-escalation.
        to_tick(1);
        set_flags(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        step();
        expect_state("emerg_again", 2'd3, 1'b0);
        to_tick(1);
        set_flags(1'b1, 1'b0, 1'b0, 1'b0);
        to_tick(1);
        expect_state("alt_normal_1", 2'd3, 1'b0);
        set_flags(1'b0, 1'b1, 1'b0, 1'b0);
        to_tick(1);
        expect_state("alt_border_1", 2'd3, 1'b0);
        set_flags(1'b1, 1'b0, 1'b0, 1'b0);
        to_tick(1);
        expect_state("alt_normal_2", 2'd3, 1'b0);
        set_flags(1'b0, 1'b1, 1'b0, 1'b0);
        to_tick(1);
        expect_state("border_held_1", 2'd3, 1'b0);
        to_tick(2);
        expect_state("border_held_3", 2'd3, 1'b0);
        to_tick(1);
        expect_state("border_held_4", 2'd1, 1'b0);
        to_tick(1);
        expect_state("border_steady", 2'd1, 1'b0);

        // No flags: request and level hold; simultaneous flags resolve to emergency.
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        to_tick(5);
        expect_state("no_flags_hold", 2'd1, 1'b0);
        set_flags(1'b0, 1'b0, 1'b1, 1'b1);
        step();
        expect_state("warn_emerg_1clk", 2'd1, 1'b0);
        step();
        expect_state("warn_emerg_both", 2'd3, 1'b0);

        // Asynchronous reset in the middle of an emergency.
        step();
        #2;
        rst = 1'b1;
        #1;
        expect_state("rst_mid_emerg", 2'd0, 1'b0);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        step();
        expect_state("post_reset_emerg", 2'd3, 1'b0);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
